// File: rtl/alu_rs_if.sv
// Dispatch, CDB and issue bundle between the ALU reservation station and its neighbours.
// master = dispatch/CDB/ALU side, slave = the reservation station itself.
interface alu_rs_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 in_valid;
  logic [4:0]           in_op;
  logic [31:0]          in_vj;
  logic [ROB_WIDTH-1:0] in_qj;
  logic                 in_qj_busy;
  logic [31:0]          in_vk;
  logic [ROB_WIDTH-1:0] in_qk;
  logic                 in_qk_busy;
  logic [ROB_WIDTH-1:0] in_rob_dest;
  logic [31:0]          in_true_jaddr;
  logic [31:0]          in_false_jaddr;
  logic                 full;

  logic                 cdb_valid;
  logic [ROB_WIDTH-1:0] cdb_rob;
  logic [31:0]          cdb_value;

  logic                 calc_enable;
  logic [31:0]          lhs;
  logic [31:0]          rhs;
  logic [4:0]           op;
  logic [ROB_WIDTH-1:0] rob_dep;
  logic [31:0]          true_jaddr;
  logic [31:0]          false_jaddr;

  modport master (
    output in_valid, in_op, in_vj, in_qj, in_qj_busy, in_vk, in_qk, in_qk_busy,
           in_rob_dest, in_true_jaddr, in_false_jaddr,
           cdb_valid, cdb_rob, cdb_value,
    input  full, calc_enable, lhs, rhs, op, rob_dep, true_jaddr, false_jaddr
  );

  modport slave (
    input  in_valid, in_op, in_vj, in_qj, in_qj_busy, in_vk, in_qk, in_qk_busy,
           in_rob_dest, in_true_jaddr, in_false_jaddr,
           cdb_valid, cdb_rob, cdb_value,
    output full, calc_enable, lhs, rhs, op, rob_dep, true_jaddr, false_jaddr
  );
endinterface

// File: rtl/alu_rs.sv
// Reservation station in front of the integer/branch ALU: holds ops until operands arrive, issues one per cycle.
// Optional RS_WAKEUP_BYPASS_EN lets an entry issue on the same edge its last operand appears on the CDB.
module alu_rs #(
  parameter int ROB_WIDTH = 4,
  parameter int RS_SIZE   = 8
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      clear,
  alu_rs_if.slave   rs
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  typedef struct packed {
    logic [4:0]           op;
    logic [31:0]          vj;
    logic [ROB_WIDTH-1:0] qj;
    logic                 qj_busy;
    logic [31:0]          vk;
    logic [ROB_WIDTH-1:0] qk;
    logic                 qk_busy;
    logic [ROB_WIDTH-1:0] rob_dest;
    logic [31:0]          true_jaddr;
    logic [31:0]          false_jaddr;
  } entry_t;

  entry_t               ent_q [RS_SIZE];
  entry_t               ent_d [RS_SIZE];
  logic [RS_SIZE-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 calc_q, calc_d;
  logic [31:0]          lhs_q, lhs_d;
  logic [31:0]          rhs_q, rhs_d;
  logic [4:0]           op_q, op_d;
  logic [ROB_WIDTH-1:0] dep_q, dep_d;
  logic [31:0]          tja_q, tja_d;
  logic [31:0]          fja_q, fja_d;

  logic [RS_SIZE-1:0]   j_hit, k_hit, ready;
  logic                 issue_found, free_found, alloc;
  logic [IDX_W-1:0]     issue_idx, free_idx;
  logic                 full;
  logic                 new_j_hit, new_k_hit;
  entry_t               new_ent;

  assign full = (count_q == CNT_W'(RS_SIZE));

  // Per-entry CDB match and readiness, all on pre-edge state.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      j_hit[i] = valid_q[i] & ent_q[i].qj_busy & rs.cdb_valid & (ent_q[i].qj == rs.cdb_rob);
      k_hit[i] = valid_q[i] & ent_q[i].qk_busy & rs.cdb_valid & (ent_q[i].qk == rs.cdb_rob);
`ifdef RS_WAKEUP_BYPASS_EN
      ready[i] = valid_q[i] & (~ent_q[i].qj_busy | j_hit[i]) & (~ent_q[i].qk_busy | k_hit[i]);
`else
      ready[i] = valid_q[i] & ~ent_q[i].qj_busy & ~ent_q[i].qk_busy;
`endif
    end
  end

  // Lowest-index ready entry and lowest-index free slot; scanning downward lets the lowest win.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign alloc = rs.in_valid & ~full & free_found;

  // Incoming entry with dispatch-time CDB capture.
  always_comb begin
    new_j_hit           = rs.in_qj_busy & rs.cdb_valid & (rs.in_qj == rs.cdb_rob);
    new_k_hit           = rs.in_qk_busy & rs.cdb_valid & (rs.in_qk == rs.cdb_rob);
    new_ent.op          = rs.in_op;
    new_ent.vj          = new_j_hit ? rs.cdb_value : rs.in_vj;
    new_ent.qj          = rs.in_qj;
    new_ent.qj_busy     = rs.in_qj_busy & ~new_j_hit;
    new_ent.vk          = new_k_hit ? rs.cdb_value : rs.in_vk;
    new_ent.qk          = rs.in_qk;
    new_ent.qk_busy     = rs.in_qk_busy & ~new_k_hit;
    new_ent.rob_dest    = rs.in_rob_dest;
    new_ent.true_jaddr  = rs.in_true_jaddr;
    new_ent.false_jaddr = rs.in_false_jaddr;
  end

  // NOTE: every signal driven here gets a hold default first, so no path infers a latch.
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    count_d = count_q;
    calc_d  = calc_q;
    lhs_d   = lhs_q;
    rhs_d   = rhs_q;
    op_d    = op_q;
    dep_d   = dep_q;
    tja_d   = tja_q;
    fja_d   = fja_q;
    if (rdy_in) begin
      if (clear) begin
        valid_d = '0;
        count_d = '0;
        calc_d  = 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (j_hit[i]) begin
            ent_d[i].vj      = rs.cdb_value;
            ent_d[i].qj_busy = 1'b0;
          end
          if (k_hit[i]) begin
            ent_d[i].vk      = rs.cdb_value;
            ent_d[i].qk_busy = 1'b0;
          end
        end
        // Reading the woken copy gives the CDB value when the bypass readiness path fired.
        calc_d = issue_found;
        if (issue_found) begin
          lhs_d              = ent_d[issue_idx].vj;
          rhs_d              = ent_d[issue_idx].vk;
          op_d               = ent_d[issue_idx].op;
          dep_d              = ent_d[issue_idx].rob_dest;
          tja_d              = ent_d[issue_idx].true_jaddr;
          fja_d              = ent_d[issue_idx].false_jaddr;
          valid_d[issue_idx] = 1'b0;
        end
        if (alloc) begin
          ent_d[free_idx]   = new_ent;
          valid_d[free_idx] = 1'b1;
        end
        count_d = count_q + CNT_W'(alloc) - CNT_W'(issue_found);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
      count_q <= '0;
      calc_q  <= 1'b0;
      lhs_q   <= '0;
      rhs_q   <= '0;
      op_q    <= 5'b11111;
      dep_q   <= '0;
      tja_q   <= '0;
      fja_q   <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      calc_q  <= calc_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
      op_q    <= op_d;
      dep_q   <= dep_d;
      tja_q   <= tja_d;
      fja_q   <= fja_d;
    end
  end

  // NOTE: entry payload is not reset; it is only ever read behind its valid bit.
  always_ff @(posedge clk_in) begin
    ent_q <= ent_d;
  end

  assign rs.full        = full;
  assign rs.calc_enable = calc_q;
  assign rs.lhs         = lhs_q;
  assign rs.rhs         = rhs_q;
  assign rs.op          = op_q;
  assign rs.rob_dep     = dep_q;
  assign rs.true_jaddr  = tja_q;
  assign rs.false_jaddr = fja_q;
endmodule
